stack_fsm_push: RTL

//  Write side of the MMU address-event (AE) stack. Accepts AEs from the spike stream over valid/ready.

---
 rtl/estu_mmu_pkg.sv | 33 +++
 rtl/stack_ptr_ctr.sv | 58 +++++
 rtl/stack_fsm_push.sv | 138 +++++++++++++
 3 files changed

// File: rtl/estu_mmu_pkg.sv
// Shared types and constants for the MMU address-event stack.
// Used by stack_fsm_push and stack_ptr_ctr.
package estu_mmu_pkg;

  // Default width of one address-event word.
  localparam int AE_W_DEF = 16;

  // Encodings of the push-side controller states.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ARM_ENC   = 2'd1;
  localparam logic [1:0] ST_WRITE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ARM   = ST_ARM_ENC,
    ST_WRITE = ST_WRITE_ENC
  } push_state_t;

  // One address-event at the default width.
  typedef logic [AE_W_DEF-1:0] ae_t;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stack_ptr_ctr.sv
// Stack pointer: up/down occupancy counter, 0..2**ADDR_W.
// full/empty are registered with sp so all three always agree.
// A decrement at zero is ignored, and an increment at full is ignored.
module stack_ptr_ctr
  import estu_mmu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [ADDR_W:0] sp,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO  = {(ADDR_W+1){1'b0}};

  logic [ADDR_W:0] sp_r;
  logic            full_r;
  logic            empty_r;
  logic            inc_s;
  logic            dec_s;
  logic [ADDR_W:0] sp_next_s;

  // Net pointer change for this cycle; simultaneous inc and dec cancel.
  always_comb begin
    inc_s     = inc & ~full_r;
    dec_s     = dec & ~empty_r;
    sp_next_s = sp_r;
    case ({inc_s, dec_s})
      2'b10:   sp_next_s = sp_r + ONE;
      2'b01:   sp_next_s = sp_r - ONE;
      default: sp_next_s = sp_r;
    endcase
  end

  // Pointer register with flags derived from the next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r    <= ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      sp_r    <= sp_next_s;
      full_r  <= (sp_next_s == DEPTH);
      empty_r <= (sp_next_s == ZERO);
    end
  end

  assign sp    = sp_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/stack_fsm_push.sv
// Write side of the MMU address-event stack.
// Accepts AEs over valid/ready in ARM, writes them at the stack pointer in WRITE.
// Throughput is one AE per two cycles.
// Optional feature macro STACK_PUSH_DROP_EN:
//   when defined, AEs offered while full are accepted and discarded and counted
//   in drop_cnt (saturating);
//   when undefined, full backpressures ae_ready and drop_cnt reads 0.
module stack_fsm_push
  import estu_mmu_pkg::*;
#(
  parameter int AE_W   = AE_W_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stream_in,
  input  logic              last_op,
  input  logic              ae_valid,
  input  logic [AE_W-1:0]   ae_data,
  output logic              ae_ready,
  input  logic              sp_dec,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [AE_W-1:0]   w_data,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              done,
  output logic [15:0]       drop_cnt
);

  push_state_t     state_r;
  logic [AE_W-1:0] ae_q_r;
  logic            done_r;
  logic            ae_ready_s;
  logic            accept_s;
  logic            push_s;
  logic [ADDR_W:0] sp_s;
  logic            full_s;
  logic            empty_s;

  stack_ptr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (push_s),
    .dec   (sp_dec),
    .sp    (sp_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Ready only in ARM; last_op always blocks acceptance.
  always_comb begin
    ae_ready_s = 1'b0;
    if (state_r == ST_ARM) begin
`ifdef STACK_PUSH_DROP_EN
      ae_ready_s = ~last_op;
`else
      ae_ready_s = ~full_s & ~last_op;
`endif
    end else begin
      ae_ready_s = 1'b0;
    end
  end

  assign accept_s = ae_valid & ae_ready_s;
  assign push_s   = (state_r == ST_WRITE);

  // Push controller: state, AE capture register and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ae_q_r  <= {AE_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (stream_in) begin
            state_r <= ST_ARM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (last_op) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end else if (accept_s && !full_s) begin
            ae_q_r  <= ae_data;
            state_r <= ST_WRITE;
          end else begin
            // Idle in ARM, or an AE accepted while full and discarded.
            state_r <= ST_ARM;
          end
        end
        ST_WRITE: begin
          // Write always completes; a pending last_op is seen back in ARM.
          state_r <= ST_ARM;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef STACK_PUSH_DROP_EN
  logic [15:0] drop_cnt_r;

  // Count AEs that were accepted while the stack was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 16'h0000;
    end else if (accept_s && full_s) begin
      drop_cnt_r <= sat_inc16(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign ae_ready = ae_ready_s;
  assign w_en     = push_s;
  assign w_addr   = push_s ? sp_s[ADDR_W-1:0] : {ADDR_W{1'b0}};
  assign w_data   = push_s ? ae_q_r : {AE_W{1'b0}};
  assign sp       = sp_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign done     = done_r;

endmodule
